// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: the display scan-out owns the port during the visible raster,
// and game-logic writers share it round-robin, one word per cycle, during blanking.
module vram_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 3,
  parameter int NUM_WR = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_hblank,
  input  logic                     i_vblank,
  input  logic [ADDR_W-1:0]        i_rd_addr,
  output logic [DATA_W-1:0]        o_rd_data,
  input  logic [NUM_WR-1:0]        i_wr_req,
  input  logic [NUM_WR*ADDR_W-1:0] i_wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] i_wr_data,
  output logic [NUM_WR-1:0]        o_wr_gnt,
  output logic [ADDR_W-1:0]        o_mem_addr,
  output logic [DATA_W-1:0]        o_mem_wdata,
  output logic                     o_mem_we,
  input  logic [DATA_W-1:0]        i_mem_rdata,
  output logic                     o_frame_pls,
  output logic [15:0]              o_wr_cnt
);

  localparam int IDX_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
  localparam int SUM_W = IDX_W + 1;

  typedef enum logic [1:0] {DISP, ARB, WR} state_t;

  state_t              state_reg;
  logic [IDX_W-1:0]    rr_ptr_reg;
  logic [IDX_W-1:0]    win_idx_reg;
  logic [ADDR_W-1:0]   wr_addr_reg;
  logic [DATA_W-1:0]   wr_data_reg;
  logic                blank_d1_reg;
  logic                blank_d2_reg;
  logic [DATA_W-1:0]   rdata_q_reg;
  logic                vblank_q_reg;
  logic                frame_pls_reg;
  logic [15:0]         wr_cnt_reg;
  logic [15:0]         wr_cnt_out_reg;

  logic                blank;
  logic                wr_fire;
  logic [IDX_W-1:0]    ptr_inc;
  logic [IDX_W-1:0]    arb_ptr;
  logic [NUM_WR-1:0]   win_onehot;
  logic [NUM_WR-1:0]   arb_req;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_found;

  logic [ADDR_W-1:0]   wr_addr_arr [NUM_WR];
  logic [DATA_W-1:0]   wr_data_arr [NUM_WR];
  logic [SUM_W-1:0]    cand_sum    [NUM_WR];
  logic [IDX_W-1:0]    cand_idx    [NUM_WR];
  logic [NUM_WR-1:0]   hit;
  logic [NUM_WR:0]     seen;
  logic [IDX_W-1:0]    pick_or     [NUM_WR+1];

  assign blank = i_hblank | i_vblank;

  // A latched write only issues if blanking persists and its requester has not withdrawn.
  assign wr_fire = (state_reg == WR) && blank && i_wr_req[win_idx_reg];

  assign ptr_inc = (win_idx_reg == IDX_W'(NUM_WR - 1)) ? '0 : win_idx_reg + 1'b1;
  assign arb_ptr = wr_fire ? ptr_inc : rr_ptr_reg;
  assign arb_req = (state_reg == WR) ? (i_wr_req & ~win_onehot) : i_wr_req;

  assign seen[0]    = 1'b0;
  assign pick_or[0] = '0;

  // Rotating priority search: slot gi examines requester (arb_ptr + gi) mod NUM_WR.
  for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_rr
    assign win_onehot[gi]  = (win_idx_reg == IDX_W'(gi));
    assign wr_addr_arr[gi] = i_wr_addr[gi*ADDR_W +: ADDR_W];
    assign wr_data_arr[gi] = i_wr_data[gi*DATA_W +: DATA_W];
    assign cand_sum[gi]    = {1'b0, arb_ptr} + SUM_W'(gi);
    assign cand_idx[gi]    = (cand_sum[gi] >= SUM_W'(NUM_WR)) ?
                             IDX_W'(cand_sum[gi] - SUM_W'(NUM_WR)) : IDX_W'(cand_sum[gi]);
    assign hit[gi]         = arb_req[cand_idx[gi]];
    assign seen[gi+1]      = seen[gi] | hit[gi];
    assign pick_or[gi+1]   = pick_or[gi] | ((hit[gi] && !seen[gi]) ? cand_idx[gi] : '0);
  end

  assign arb_idx   = pick_or[NUM_WR];
  assign arb_found = seen[NUM_WR];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg   <= DISP;
      rr_ptr_reg  <= '0;
      win_idx_reg <= '0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else if (!blank) begin
      state_reg <= DISP;
    end else begin
      case (state_reg)
        DISP: state_reg <= ARB;
        ARB, WR: begin
          if (wr_fire) rr_ptr_reg <= ptr_inc;
          if (arb_found) begin
            win_idx_reg <= arb_idx;
            wr_addr_reg <= wr_addr_arr[arb_idx];
            wr_data_reg <= wr_data_arr[arb_idx];
            state_reg   <= WR;
          end else begin
            state_reg <= ARB;
          end
        end
        default: state_reg <= DISP;
      endcase
    end
  end

  assign o_mem_we    = wr_fire;
  assign o_wr_gnt    = wr_fire ? win_onehot : '0;
  assign o_mem_wdata = wr_fire ? wr_data_reg : '0;
  assign o_mem_addr  = !i_rst_n ? '0 : (wr_fire ? wr_addr_reg : i_rd_addr);

  // Blank travels alongside the RAM read so pixels fetched at the raster edge are masked.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      blank_d1_reg <= 1'b1;
      blank_d2_reg <= 1'b1;
      rdata_q_reg  <= '0;
    end else begin
      blank_d1_reg <= blank;
      blank_d2_reg <= blank_d1_reg;
      rdata_q_reg  <= i_mem_rdata;
    end
  end

  assign o_rd_data = blank_d2_reg ? '0 : rdata_q_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vblank_q_reg   <= 1'b0;
      frame_pls_reg  <= 1'b0;
      wr_cnt_reg     <= '0;
      wr_cnt_out_reg <= '0;
    end else begin
      vblank_q_reg  <= i_vblank;
      frame_pls_reg <= i_vblank & ~vblank_q_reg;
      if (frame_pls_reg) begin
        wr_cnt_out_reg <= wr_cnt_reg;
        wr_cnt_reg     <= wr_fire ? 16'd1 : 16'd0;
      end else if (wr_fire && (wr_cnt_reg != 16'hFFFF)) begin
        wr_cnt_reg <= wr_cnt_reg + 16'd1;
      end
    end
  end

  assign o_frame_pls = frame_pls_reg;
  assign o_wr_cnt    = wr_cnt_out_reg;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous RAM on the memory port.
module tb_vram_arbiter;
  localparam int AW = 15;
  localparam int DW = 3;
  localparam int NW = 2;

  logic            i_clk = 1'b0;
  logic            i_rst_n;
  logic            i_hblank, i_vblank;
  logic [AW-1:0]   i_rd_addr;
  logic [DW-1:0]   o_rd_data;
  logic [NW-1:0]   i_wr_req;
  logic [NW*AW-1:0] i_wr_addr;
  logic [NW*DW-1:0] i_wr_data;
  logic [NW-1:0]   o_wr_gnt;
  logic [AW-1:0]   o_mem_addr;
  logic [DW-1:0]   o_mem_wdata;
  logic            o_mem_we;
  logic [DW-1:0]   mem_rdata;
  logic            o_frame_pls;
  logic [15:0]     o_wr_cnt;

  logic [AW-1:0]   wa0, wa1;
  logic [DW-1:0]   wd0, wd1;
  assign i_wr_addr = {wa1, wa0};
  assign i_wr_data = {wd1, wd0};

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks   = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NUM_WR(NW)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_hblank    (i_hblank),
    .i_vblank    (i_vblank),
    .i_rd_addr   (i_rd_addr),
    .o_rd_data   (o_rd_data),
    .i_wr_req    (i_wr_req),
    .i_wr_addr   (i_wr_addr),
    .i_wr_data   (i_wr_data),
    .o_wr_gnt    (o_wr_gnt),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_we    (o_mem_we),
    .i_mem_rdata (mem_rdata),
    .o_frame_pls (o_frame_pls),
    .o_wr_cnt    (o_wr_cnt)
  );

  always @(posedge i_clk) begin
    if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
    mem_rdata <= mem[o_mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after a falling edge; outputs are sampled 1 time unit later.
  task automatic cyc();
    @(negedge i_clk);
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
    mem[16] = 3'd5;
    i_rst_n = 1'b0; i_hblank = 1'b0; i_vblank = 1'b0;
    i_rd_addr = 15'h0010; i_wr_req = 2'b00;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;

    // Test 1: reset values, then display read latency
    cyc(); cyc(); #1;
    chk("rst_we", o_mem_we, 0);
    chk("rst_addr", o_mem_addr, 0);
    chk("rst_rd_data", o_rd_data, 0);
    chk("rst_gnt", o_wr_gnt, 0);
    chk("rst_frame_pls", o_frame_pls, 0);
    chk("rst_wr_cnt", o_wr_cnt, 0);
    cyc(); i_rst_n = 1'b1; #1;
    chk("disp_addr", o_mem_addr, 15'h0010);
    chk("disp_we", o_mem_we, 0);
    cyc(); #1;
    chk("rd_lat1", o_rd_data, 0);
    cyc(); #1;
    chk("rd_lat2", o_rd_data, 5);

    // Test 2: two writers held, alternating back-to-back grants
    cyc(); i_hblank = 1'b1; i_wr_req = 2'b11;
    wa0 = 15'h0100; wd0 = 3'd1; wa1 = 15'h0200; wd1 = 3'd2; #1;
    chk("b0_we", o_mem_we, 0);
    cyc(); #1;
    chk("b1_gnt", o_wr_gnt, 0);
    cyc(); #1;
    chk("b2_gnt", o_wr_gnt, 2'b01);
    chk("b2_addr", o_mem_addr, 15'h0100);
    chk("b2_wdata", o_mem_wdata, 1);
    cyc(); #1;
    chk("b3_gnt", o_wr_gnt, 2'b10);
    chk("b3_addr", o_mem_addr, 15'h0200);
    chk("b3_wdata", o_mem_wdata, 2);
    cyc(); #1;
    chk("b4_gnt", o_wr_gnt, 2'b01);
    cyc(); #1;
    chk("b5_gnt", o_wr_gnt, 2'b10);
    cyc(); i_wr_req = 2'b00; #1;
    chk("b6_we", o_mem_we, 0);
    chk("b6_ram0", mem[16'h0100], 1);
    chk("b6_ram1", mem[16'h0200], 2);

    // Test 3: blank falls with a latched write pending
    cyc(); i_wr_req = 2'b01; wa0 = 15'h0101; wd0 = 3'd3; #1;
    chk("c0_gnt", o_wr_gnt, 0);
    cyc(); i_wr_req = 2'b11; wa1 = 15'h0201; wd1 = 3'd4; #1;
    chk("c1_gnt", o_wr_gnt, 2'b01);
    cyc(); i_hblank = 1'b0; i_wr_req = 2'b10; #1;
    chk("c2_gnt", o_wr_gnt, 0);
    chk("c2_we", o_mem_we, 0);
    chk("c2_addr", o_mem_addr, 15'h0010);
    cyc(); #1;
    chk("c3_gnt", o_wr_gnt, 0);
    cyc(); i_hblank = 1'b1; #1;
    chk("c4_gnt", o_wr_gnt, 0);
    cyc(); #1;
    chk("c5_gnt", o_wr_gnt, 0);
    cyc(); #1;
    chk("c6_gnt", o_wr_gnt, 2'b10);
    chk("c6_addr", o_mem_addr, 15'h0201);
    cyc(); i_wr_req = 2'b00; #1;
    chk("c7_ram1", mem[16'h0201], 4);

    // Test 4: writer 1 withdraws in its grant cycle; pointer must not move
    cyc(); i_wr_req = 2'b01; wa0 = 15'h0102; wd0 = 3'd6; #1;
    cyc(); #1;
    chk("d1_gnt", o_wr_gnt, 2'b01);
    cyc(); i_wr_req = 2'b10; wa1 = 15'h0202; wd1 = 3'd5; #1;
    cyc(); i_wr_req = 2'b00; #1;
    chk("d3_gnt", o_wr_gnt, 0);
    chk("d3_we", o_mem_we, 0);
    cyc(); i_wr_req = 2'b11; wa1 = 15'h0203; wd1 = 3'd7; #1;
    cyc(); #1;
    chk("d5_gnt", o_wr_gnt, 2'b10);
    cyc(); i_wr_req = 2'b01; #1;
    chk("d6_gnt", o_wr_gnt, 2'b01);
    cyc(); i_wr_req = 2'b00; #1;
    chk("d7_ram_cancel", mem[16'h0202], 0);
    chk("d7_ram_w1", mem[16'h0203], 7);

    // Test 5: frame pulse and per-frame write count (9 writes so far, then 7)
    cyc(); i_vblank = 1'b1; #1;
    chk("e0_pls", o_frame_pls, 0);
    cyc(); #1;
    chk("e1_pls", o_frame_pls, 1);
    cyc(); i_wr_req = 2'b11; #1;
    chk("e2_pls", o_frame_pls, 0);
    chk("e2_cnt", o_wr_cnt, 9);
    for (int k = 0; k < 7; k++) begin
      cyc(); #1;
      chk($sformatf("e_burst%0d_gnt", k), o_wr_gnt, (k % 2 == 0) ? 2'b10 : 2'b01);
    end
    cyc(); i_wr_req = 2'b00; #1;
    chk("e10_gnt", o_wr_gnt, 0);
    cyc(); i_vblank = 1'b0; #1;
    cyc(); i_vblank = 1'b1; #1;
    chk("e12_pls", o_frame_pls, 0);
    cyc(); #1;
    chk("e13_pls", o_frame_pls, 1);
    cyc(); #1;
    chk("e14_pls", o_frame_pls, 0);
    chk("e14_cnt", o_wr_cnt, 7);

    // Test 6: reset in the middle of a burst
    cyc(); i_vblank = 1'b0; i_wr_req = 2'b11; #1;
    cyc(); #1;
    chk("f1_gnt", o_wr_gnt, 2'b01);
    cyc(); i_rst_n = 1'b0; #1;
    chk("f2_we", o_mem_we, 0);
    chk("f2_gnt", o_wr_gnt, 0);
    chk("f2_rd_data", o_rd_data, 0);
    chk("f2_addr", o_mem_addr, 0);
    chk("f2_cnt", o_wr_cnt, 0);
    cyc(); i_rst_n = 1'b1; #1;
    chk("f3_gnt", o_wr_gnt, 0);
    cyc(); #1;
    chk("f4_gnt", o_wr_gnt, 0);
    cyc(); #1;
    chk("f5_gnt", o_wr_gnt, 2'b01);
    cyc(); i_wr_req = 2'b00;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
